slave_rx_burst: RTL and testbench
=================================

SLAVE_RX_BURST -- requirements
Module: slave_rx_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per beat.
REQ-002 SHALL have parameter ADDR_W, default 12, address bits.
REQ-003 SHALL have parameter BURST_W, default 8, burst-length field bits.
REQ-004 SHALL use reset reset, synchronous, active-high; clock clk.
REQ-005 clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-006 write_enable  in  1  master write request; read_enable  in  1  master read request.
REQ-007 burst_en  in  1  write is a burst, sampled on IDLE exit.
REQ-008 master_valid  in  1  serial bit valid; slave_ready  out  1  slave accepts a bit.
REQ-009 rx_addr, rx_burst, rx_data  in  1 each  serial address, burst-length and data lines.
REQ-010 mem_busy  in  1  downstream cannot accept a write beat.
REQ-011 wr_valid  out  1; wr_addr  out  ADDR_W; wr_data  out  DATA_W; wr_last  out  1  write beat port.
REQ-012 rd_req  out  1; rd_addr  out  ADDR_W; rd_done  in  1  read request port.
REQ-013 busy  out  1  state != IDLE; err  out  1  one-cycle protocol-error pulse.

Function
REQ-014 SHALL capture one bit per handshake (master_valid & slave_ready); the i-th bit of a field goes to bit i (LSB-first).
REQ-015 States: IDLE, ADDR, BURST, DATA, COMMIT, READ_WAIT; slave_ready SHALL be 1 only in ADDR, BURST, DATA.
REQ-016 IDLE: write_enable & !read_enable -> ADDR (write mode); read_enable & !write_enable -> ADDR (read mode); both high -> stay IDLE, err pulse.
REQ-017 ADDR: after ADDR_W bits on rx_addr, store base address; read mode -> READ_WAIT; write with burst_en -> BURST; else -> DATA with beat count 1.
REQ-018 BURST: after BURST_W bits on rx_burst -> DATA; beat count = field value, value 0 treated as 1.
REQ-019 DATA: after DATA_W bits on rx_data -> COMMIT the next cycle; bit counter cleared.
REQ-020 COMMIT: wr_valid SHALL be 1 for exactly one cycle, the first COMMIT cycle with mem_busy==0; held off while mem_busy==1.
REQ-021 wr_addr = (base + beat index) mod 2^ADDR_W, beat index from 0; wr_data = assembled beat.
REQ-022 wr_last SHALL be 1 with wr_valid on the final beat; then -> IDLE; otherwise -> DATA.
REQ-023 READ_WAIT: rd_req=1, rd_addr=base; on rd_done -> IDLE, rd_req 0 the following cycle.
REQ-024 Write-mode abort: write_enable low in ADDR/BURST/DATA/COMMIT -> IDLE next cycle, err pulse, no wr_valid for a partial or uncommitted beat.
REQ-025 Read-mode abort: read_enable low in ADDR/READ_WAIT -> IDLE, err pulse, rd_req dropped.
REQ-026 master_valid while slave_ready==0 SHALL be ignored (no bit captured).
REQ-027 wr_addr, wr_data, rd_addr SHALL hold last values outside their valid cycles.

Reset
REQ-028 reset SHALL force state IDLE and clear all counters and registers.
REQ-029 After reset all outputs SHALL be 0, including slave_ready, wr_*, rd_*, busy, err.
REQ-030 reset mid-transaction SHALL discard it with no wr_valid, rd_req or err.

Structure
REQ-031 State encoding and default widths SHALL live in shared package slave_bus_pkg.
REQ-032 One sub-module serial_shift_rx (parameter WIDTH; LSB-first shift register plus bit counter, done flag) SHALL be instantiated per serial field.

Verification
REQ-033 Single write: addr 0x0A5, burst_en=0, data 0x3C -> one wr_valid, wr_addr 0x0A5, wr_data 0x3C, wr_last=1.
REQ-034 Burst wrap: addr 0xFFE, burst 3, data 0x11,0x22,0x33 -> wr_addr 0xFFE,0xFFF,0x000; wr_last only on third.
REQ-035 Backpressure: mem_busy=1 for 5 cycles at COMMIT -> wr_valid delayed 5 cycles, single pulse, data unchanged.
REQ-036 Read: read_enable, addr 0x123 -> rd_req=1, rd_addr 0x123 until rd_done; busy falls next cycle.
REQ-037 Abort/conflict: write_enable dropped after 4 data bits -> err pulse, no wr_valid; both enables high in IDLE -> err, stay IDLE.
REQ-038 Reset after 6 address bits, then clean single write 0x200/0xAA -> only wr_addr 0x200, wr_data 0xAA observed.

Source files
------------

// File: rtl/slave_bus_pkg.sv
// Shared definitions for the serial burst slave: state encoding, default widths
// and a small state-decode helper.
package slave_bus_pkg;

    localparam int SLV_DATA_W  = 8;
    localparam int SLV_ADDR_W  = 12;
    localparam int SLV_BURST_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_BURST     = 3'd2,
        ST_DATA      = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_READ_WAIT = 3'd5
    } slv_state_e;

    // Only the three serial-capture phases accept bits from the master.
    function automatic logic is_ready_state(input slv_state_e s);
        case (s)
            ST_ADDR, ST_BURST, ST_DATA: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_shift_rx.sv
// LSB-first serial field receiver: shift register plus bit counter; done_o marks
// the cycle in which the final bit is accepted, field_o then already includes it.
module serial_shift_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] field_o,
    output logic             done_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state for counter and shift register.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        done_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            // Shifting in at the MSB end leaves the first bit at bit 0 after WIDTH shifts.
            data_d = {bit_i, data_q[WIDTH-1:1]};
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign field_o = data_d;

endmodule

// File: rtl/slave_rx_burst.sv
// Serial bus slave: receives address, optional burst length and data beats
// bit-serially, then issues write beats or a single read request downstream.
module slave_rx_burst
    import slave_bus_pkg::*;
#(
    parameter int DATA_W  = SLV_DATA_W,
    parameter int ADDR_W  = SLV_ADDR_W,
    parameter int BURST_W = SLV_BURST_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic              burst_en,
    input  logic              master_valid,
    output logic              slave_ready,
    input  logic              rx_addr,
    input  logic              rx_burst,
    input  logic              rx_data,
    input  logic              mem_busy,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_last,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    output logic              busy,
    output logic              err
);

    slv_state_e         state_q, state_d;
    logic               write_mode_q, write_mode_d;
    logic               burst_mode_q, burst_mode_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic [BURST_W-1:0] beat_idx_q, beat_idx_d;
    logic [DATA_W-1:0]  beat_data_q, beat_data_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               err_q, err_d;

    logic               handshake_s;
    logic               fields_clear_s;
    logic               addr_shift_s, burst_shift_s, data_shift_s;
    logic               addr_done_s, burst_done_s, data_done_s;
    logic [ADDR_W-1:0]  addr_field_s;
    logic [BURST_W-1:0] burst_field_s;
    logic [DATA_W-1:0]  data_field_s;
    logic               abort_s;
    logic               last_beat_s;
    logic [ADDR_W-1:0]  beat_addr_s;
    logic               wr_valid_s;

    assign slave_ready    = is_ready_state(state_q);
    assign handshake_s    = master_valid & slave_ready;
    assign fields_clear_s = (state_q == ST_IDLE);
    assign addr_shift_s   = handshake_s & (state_q == ST_ADDR);
    assign burst_shift_s  = handshake_s & (state_q == ST_BURST);
    assign data_shift_s   = handshake_s & (state_q == ST_DATA);

    serial_shift_rx #(.WIDTH(ADDR_W)) u_addr_rx (
        .clk     (clk),
        .reset   (reset),
        .clear_i (fields_clear_s),
        .shift_i (addr_shift_s),
        .bit_i   (rx_addr),
        .field_o (addr_field_s),
        .done_o  (addr_done_s)
    );

    serial_shift_rx #(.WIDTH(BURST_W)) u_burst_rx (
        .clk     (clk),
        .reset   (reset),
        .clear_i (fields_clear_s),
        .shift_i (burst_shift_s),
        .bit_i   (rx_burst),
        .field_o (burst_field_s),
        .done_o  (burst_done_s)
    );

    serial_shift_rx #(.WIDTH(DATA_W)) u_data_rx (
        .clk     (clk),
        .reset   (reset),
        .clear_i (fields_clear_s),
        .shift_i (data_shift_s),
        .bit_i   (rx_data),
        .field_o (data_field_s),
        .done_o  (data_done_s)
    );

    // Dropping the enable that started the transaction abandons it.
    assign abort_s     = write_mode_q ? ~write_enable : ~read_enable;
    assign last_beat_s = (beat_idx_q == (beats_q - BURST_W'(1)));
    assign beat_addr_s = base_q + ADDR_W'(beat_idx_q);

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d      = state_q;
        write_mode_d = write_mode_q;
        burst_mode_d = burst_mode_q;
        base_d       = base_q;
        beats_d      = beats_q;
        beat_idx_d   = beat_idx_q;
        beat_data_d  = beat_data_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        err_d        = 1'b0;
        wr_valid_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write_enable && read_enable) begin
                    err_d = 1'b1;
                end else if (write_enable) begin
                    state_d      = ST_ADDR;
                    write_mode_d = 1'b1;
                    burst_mode_d = burst_en;
                end else if (read_enable) begin
                    state_d      = ST_ADDR;
                    write_mode_d = 1'b0;
                    burst_mode_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (addr_done_s) begin
                    base_d = addr_field_s;
                    if (!write_mode_q) begin
                        state_d   = ST_READ_WAIT;
                        rd_addr_d = addr_field_s;
                    end else if (burst_mode_q) begin
                        state_d = ST_BURST;
                    end else begin
                        state_d    = ST_DATA;
                        beats_d    = BURST_W'(1);
                        beat_idx_d = '0;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_BURST: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (burst_done_s) begin
                    state_d    = ST_DATA;
                    beats_d    = (burst_field_s == '0) ? BURST_W'(1) : burst_field_s;
                    beat_idx_d = '0;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_DATA: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (data_done_s) begin
                    state_d     = ST_COMMIT;
                    beat_data_d = data_field_s;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_COMMIT: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (!mem_busy) begin
                    wr_valid_s = 1'b1;
                    wr_addr_d  = beat_addr_s;
                    wr_data_d  = beat_data_q;
                    if (last_beat_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        beat_idx_d = beat_idx_q + BURST_W'(1);
                    end
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_READ_WAIT: begin
                if (!read_enable) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rd_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_mode_q <= 1'b0;
            burst_mode_q <= 1'b0;
            base_q       <= '0;
            beats_q      <= '0;
            beat_idx_q   <= '0;
            beat_data_q  <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_addr_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_mode_q <= write_mode_d;
            burst_mode_q <= burst_mode_d;
            base_q       <= base_d;
            beats_q      <= beats_d;
            beat_idx_q   <= beat_idx_d;
            beat_data_q  <= beat_data_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_addr_q    <= rd_addr_d;
            err_q        <= err_d;
        end
    end

    // The write port shows the live beat in its valid cycle and the last beat otherwise.
    assign wr_valid = wr_valid_s;
    assign wr_addr  = wr_valid_s ? beat_addr_s : wr_addr_q;
    assign wr_data  = wr_valid_s ? beat_data_q : wr_data_q;
    assign wr_last  = wr_valid_s & last_beat_s;
    assign rd_req   = (state_q == ST_READ_WAIT);
    assign rd_addr  = rd_addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_slave_rx_burst.sv
// Directed bench for slave_rx_burst: single write, wrapping burst, backpressure,
// read, abort, enable conflict and mid-transaction reset.
module tb_slave_rx_burst;

    logic        clk = 1'b0;
    logic        reset, write_enable, read_enable, burst_en, master_valid;
    logic        rx_addr, rx_burst, rx_data, mem_busy, rd_done;
    logic        slave_ready, wr_valid, wr_last, rd_req, busy, err;
    logic [11:0] wr_addr, rd_addr;
    logic [7:0]  wr_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_cnt = 0;
    logic [11:0] wa[$];
    logic [7:0]  wd[$];
    logic        wl[$];
    int          wc[$];

    slave_rx_burst #(.DATA_W(8), .ADDR_W(12), .BURST_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .burst_en     (burst_en),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rx_addr      (rx_addr),
        .rx_burst     (rx_burst),
        .rx_data      (rx_data),
        .mem_busy     (mem_busy),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_done      (rd_done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write beat and error pulse half a cycle after the edge.
    always @(negedge clk) begin
        if (wr_valid) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wl.push_back(wr_last);
            wc.push_back(cyc);
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wl.delete(); wc.delete();
    endtask

    task automatic send_bits(input int sel, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            master_valid = 1'b1;
            case (sel)
                0:       rx_addr  = v[i];
                1:       rx_burst = v[i];
                default: rx_data  = v[i];
            endcase
            tick();
        end
        master_valid = 1'b0;
        rx_addr = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (k < 20 && busy && !slave_ready) begin
            tick();
            k++;
        end
        check(tag, 32'(k < 20), 32'd1);
    endtask

    task automatic write_op(input logic [11:0] a, input logic bf, input logic [7:0] bl,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input int nb);
        logic [7:0] dv;
        write_enable = 1'b1;
        burst_en = bf;
        tick();
        burst_en = 1'b0;
        send_bits(0, {4'h0, a}, 12);
        if (bf) send_bits(1, {8'h00, bl}, 8);
        for (int b = 0; b < nb; b++) begin
            dv = (b == 0) ? d0 : ((b == 1) ? d1 : d2);
            send_bits(2, {8'h00, dv}, 8);
            wait_done("commit_wait");
        end
        write_enable = 1'b0;
    endtask

    task automatic check_beat(input int i, input logic [11:0] a, input logic [7:0] d, input logic l);
        check($sformatf("beat%0d_addr", i), 32'(wa[i]), 32'(a));
        check($sformatf("beat%0d_data", i), 32'(wd[i]), 32'(d));
        check($sformatf("beat%0d_last", i), 32'(wl[i]), 32'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int e0;
        reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0; burst_en = 1'b0;
        master_valid = 1'b0; rx_addr = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
        mem_busy = 1'b0; rd_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(slave_ready), 32'd0);
        check("rst_wr", 32'({wr_valid, wr_last, wr_addr, wr_data}), 32'd0);
        check("rst_rd", 32'({rd_req, rd_addr}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single write
        clear_log();
        write_op(12'h0A5, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h00, 1);
        tick();
        check("single_count", 32'(wa.size()), 32'd1);
        check_beat(0, 12'h0A5, 8'h3C, 1'b1);
        check("hold_addr", 32'(wr_addr), 32'h0A5);
        check("hold_data", 32'(wr_data), 32'h3C);

        // Burst of three wrapping past the top of the address space
        clear_log();
        write_op(12'hFFE, 1'b1, 8'd3, 8'h11, 8'h22, 8'h33, 3);
        tick();
        check("burst_count", 32'(wa.size()), 32'd3);
        check_beat(0, 12'hFFE, 8'h11, 1'b0);
        check_beat(1, 12'hFFF, 8'h22, 1'b0);
        check_beat(2, 12'h000, 8'h33, 1'b1);

        // Backpressure: five busy cycles in COMMIT, stray master bits ignored
        clear_log();
        write_enable = 1'b1;
        tick();
        send_bits(0, 16'h0010, 12);
        mem_busy = 1'b1;
        send_bits(2, 16'h003C, 8);
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            check("bp_held", 32'(wr_valid), 32'd0);
            master_valid = 1'b1;
            rx_data = 1'b1;
            tick();
        end
        master_valid = 1'b0;
        rx_data = 1'b0;
        mem_busy = 1'b0;
        #1;
        check("bp_valid", 32'(wr_valid), 32'd1);
        wait_done("bp_wait");
        write_enable = 1'b0;
        tick();
        check("bp_count", 32'(wa.size()), 32'd1);
        check("bp_delay", 32'(wc[0] - t0), 32'd5);
        check_beat(0, 12'h010, 8'h3C, 1'b1);

        // Read request
        read_enable = 1'b1;
        tick();
        send_bits(0, 16'h0123, 12);
        check("rd_req", 32'(rd_req), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'h123);
        repeat (3) tick();
        check("rd_req_hold", 32'({rd_req, busy}), 32'h3);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        read_enable = 1'b0;
        #1;
        check("rd_req_drop", 32'(rd_req), 32'd0);
        check("rd_busy_drop", 32'(busy), 32'd0);
        check("rd_addr_hold", 32'(rd_addr), 32'h123);

        // Write abort after four data bits
        clear_log();
        write_enable = 1'b1;
        tick();
        send_bits(0, 16'h0055, 12);
        send_bits(2, 16'h00FF, 4);
        write_enable = 1'b0;
        tick();
        check("abort_err", 32'(err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        check("abort_err_pulse", 32'(err), 32'd0);
        repeat (3) tick();
        check("abort_no_wr", 32'(wa.size()), 32'd0);

        // Both enables in IDLE
        write_enable = 1'b1;
        read_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        read_enable = 1'b0;
        check("conflict_err", 32'(err), 32'd1);
        check("conflict_idle", 32'(busy), 32'd0);
        tick();
        check("conflict_pulse", 32'({err, busy}), 32'd0);

        // Reset part-way through the address, then a clean write
        clear_log();
        tick();
        e0 = err_cnt;
        write_enable = 1'b1;
        tick();
        send_bits(0, 16'h003F, 6);
        reset = 1'b1;
        write_enable = 1'b0;
        tick();
        reset = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        write_op(12'h200, 1'b0, 8'h00, 8'hAA, 8'h00, 8'h00, 1);
        repeat (2) tick();
        check("mrst_count", 32'(wa.size()), 32'd1);
        check_beat(0, 12'h200, 8'hAA, 1'b1);
        check("mrst_no_err", 32'(err_cnt - e0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
